// File: rtl/gray_ptr.sv
// Gray-coded FIFO pointer counters for the sync-bridge asynchronous FIFO.
// gray_ptr_cnt is the shared counter core: a binary count plus a Gray-coded
// output register. wr_ptr_gray and rd_ptr_gray are the write- and read-side
// pointers built on that core. gray_ptr groups one of each. The two pointers
// share a clock and reset here, but they hold independent state and have no
// logic in common.

module gray_ptr_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetb,  // asynchronous, active-high
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] out_reg;

    // The increment wraps modulo 2^WIDTH. It has no saturation and no
    // full/empty detection.
    assign bin_next = bin_reg + WIDTH'(1);

    // Gray(x) = x ^ (x >> 1). The MSB passes through unchanged, and every
    // other bit is XORed with its upper neighbour.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray
        if (gi == WIDTH - 1) begin : g_msb
            assign gray_next[gi] = bin_next[gi];
        end else begin : g_low
            assign gray_next[gi] = bin_next[gi] ^ bin_next[gi + 1];
        end
    end

    // Update the binary count and its registered Gray image together.
    // The Gray value is encoded ahead of the flop, so out has no logic after
    // the register and is safe to sample from another clock domain.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            bin_reg <= '0;
            out_reg <= '0;
        end else if (en) begin
            bin_reg <= bin_next;
            out_reg <= gray_next;
        end
    end

    assign out = out_reg;

endmodule

module wr_ptr_gray #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    // Write-side pointer. It has no state beyond the counter core.
    gray_ptr_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .resetb (resetb),
        .en     (en),
        .out    (out)
    );

endmodule

module rd_ptr_gray #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    // Read-side pointer. It has the same behaviour as the write side.
    gray_ptr_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .resetb (resetb),
        .en     (en),
        .out    (out)
    );

endmodule

module gray_ptr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] wr_out,
    output logic [WIDTH-1:0] rd_out
);

    // One independent pointer for each side of the FIFO.
    wr_ptr_gray #(.WIDTH(WIDTH)) u_wr (
        .clk    (clk),
        .resetb (resetb),
        .en     (wr_en),
        .out    (wr_out)
    );

    rd_ptr_gray #(.WIDTH(WIDTH)) u_rd (
        .clk    (clk),
        .resetb (resetb),
        .en     (rd_en),
        .out    (rd_out)
    );

endmodule

// File: tb/tb_gray_ptr.sv
// Directed testbench for gray_ptr. Both pointers always receive the same
// enable, so every check covers the write side and the read side.
`timescale 1ns/1ps

module tb_gray_ptr;

    localparam int WIDTH = 4;

    logic             clk;
    logic             resetb;
    logic             en;
    logic [WIDTH-1:0] wr_out;
    logic [WIDTH-1:0] rd_out;

    int total = 0;
    int bad   = 0;

    // Hand-computed WIDTH=4 Gray sequence: the value after k steps from reset.
    logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    gray_ptr #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetb (resetb),
        .wr_en  (en),
        .rd_en  (en),
        .wr_out (wr_out),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Check both pointers against one expected value.
    task automatic chk_both(input string tag, input logic [3:0] exp);
        chk({tag, "_wr"}, 32'(wr_out), 32'(exp));
        chk({tag, "_rd"}, 32'(rd_out), 32'(exp));
    endtask

    // Advance to 1 ns after the next rising edge. Inputs are driven and
    // outputs are sampled at that point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetb = 1'b1;
        en     = 1'b0;
        tick();
        tick();
        resetb = 1'b0;
    endtask

    // Apply one single-cycle enable pulse.
    task automatic pulse();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    logic [3:0] prev;

    initial begin
        resetb = 1'b1;
        en     = 1'b0;
        #1;
        chk_both("reset_async", 4'h0);

        // Toggle en while reset is held. Reset must win on every edge.
        for (int i = 0; i < 4; i++) begin
            en = ~en;
            tick();
            chk_both($sformatf("reset_hold%0d", i), 4'h0);
        end
        en     = 1'b0;
        resetb = 1'b0;

        // Apply 16 single pulses, each followed by two idle cycles.
        // The pointer must step once per pulse and hold in between.
        prev = 4'h0;
        for (int i = 1; i <= 16; i++) begin
            pulse();
            chk_both($sformatf("step%0d", i), gseq[i % 16]);
            chk($sformatf("step%0d_ham", i), 32'($countones(wr_out ^ prev)), 32'd1);
            prev = wr_out;
            tick();
            chk_both($sformatf("step%0d_idle1", i), gseq[i % 16]);
            tick();
            chk_both($sformatf("step%0d_idle2", i), gseq[i % 16]);
        end

        // Apply 50 pulses from reset. The pointer wraps three times and ends
        // at Gray(2) = 3. Each step must change exactly one bit.
        do_reset();
        prev = 4'h0;
        for (int i = 1; i <= 50; i++) begin
            pulse();
            chk($sformatf("long%0d", i), 32'(wr_out), 32'(gseq[i % 16]));
            chk($sformatf("long%0d_ham", i), 32'($countones(wr_out ^ prev)), 32'd1);
            chk($sformatf("long%0d_lock", i), 32'(rd_out), 32'(gseq[i % 16]));
            prev = wr_out;
        end
        chk_both("long_final", 4'h3);

        // Hold en high for 5 cycles. The pointer advances once per edge.
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_both($sformatf("cont%0d", i), gseq[i]);
        end
        en = 1'b0;
        tick();
        chk_both("cont_hold", 4'h7);

        // Assert reset between edges after 6 steps. The output must clear
        // before the next rising edge.
        do_reset();
        for (int i = 0; i < 6; i++) pulse();
        chk_both("mid_pre", 4'h5);
        #2;
        resetb = 1'b1;
        #1;
        chk_both("mid_async_clear", 4'h0);
        tick();
        chk_both("mid_held", 4'h0);
        resetb = 1'b0;
        pulse();
        chk_both("mid_restart", 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net in case the run stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
